// File: rtl/tdc_hit_readout.sv
// tdc_hit_readout: timestamps the first rising/falling HIT edge inside each
// sequencer measurement window, counts rising edges, and queues one 32-bit
// record per window in a FIFO that the host pops.
module tdc_hit_readout #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        measure_flag,
  input  logic [3:0]  SEL,
  input  logic        HIT,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic        busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [9:0] T_MAX = 10'h3FF;

  typedef enum logic [2:0] {IDLE, ARMED, HIGH, DONE_WAIT, WRITE} state_t;

  state_t state, state_next;

  logic hs_meta, hs, hs_prev;
  logic mf_r, start_block;
  logic win_start, hs_rise, hs_fall;
  logic [9:0] t_cnt;
  logic [3:0] sel_r;
  logic [9:0] rise_t, fall_t;
  logic [3:0] n_rise;
  logic hit_seen, fall_seen, started_high;
  logic do_write, set_rise, set_fall, inc_rise, start_hi;
  logic [31:0] record;

  logic [31:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count, count_next;
  logic wr_accept, pop, drop;

  assign hs_rise   = hs & ~hs_prev;
  assign hs_fall   = ~hs & hs_prev;
  // start_block suppresses a window whose flag was already high at reset release
  assign win_start = measure_flag & ~mf_r & ~start_block;
  assign busy      = (state == ARMED) || (state == HIGH) || (state == WRITE);

  // HIT synchronizer, edge-history flop and measure_flag edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_meta     <= 1'b0;
      hs          <= 1'b0;
      hs_prev     <= 1'b0;
      mf_r        <= 1'b0;
      start_block <= 1'b1;
    end else begin
      hs_meta <= HIT;
      hs      <= hs_meta;
      hs_prev <= hs;
      mf_r    <= measure_flag;
      if (!measure_flag) start_block <= 1'b0;
    end
  end

  // Window timebase: holds 0 on the start cycle as seen by the FSM, saturates at 1023
  always_ff @(posedge clk) begin
    if (!reset) begin
      t_cnt <= '0;
      sel_r <= '0;
    end else if (win_start) begin
      t_cnt <= 10'd1;
      sel_r <= SEL;
    end else if (t_cnt != T_MAX) begin
      t_cnt <= t_cnt + 10'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-cycle actions; a falling flag wins over any edge
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    set_rise   = 1'b0;
    set_fall   = 1'b0;
    inc_rise   = 1'b0;
    start_hi   = 1'b0;
    case (state)
      IDLE: begin
        if (win_start) begin
          if (hs) begin
            state_next = HIGH;
            start_hi   = 1'b1;
          end else begin
            state_next = ARMED;
          end
        end
      end
      ARMED: begin
        if (!measure_flag) begin
          state_next = WRITE;
        end else if (hs_rise) begin
          set_rise   = 1'b1;
          inc_rise   = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (!measure_flag) begin
          state_next = WRITE;
        end else if (hs_fall) begin
          set_fall   = 1'b1;
          state_next = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (!measure_flag) state_next = WRITE;
        else if (hs_rise)  inc_rise   = 1'b1;
      end
      WRITE: begin
        do_write = 1'b1;
        // a back-to-back window may start on this very cycle
        if (win_start) begin
          if (hs) begin
            state_next = HIGH;
            start_hi   = 1'b1;
          end else begin
            state_next = ARMED;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Window result registers: cleared after each record, then updated by FSM actions
  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_t       <= '0;
      fall_t       <= '0;
      n_rise       <= '0;
      hit_seen     <= 1'b0;
      fall_seen    <= 1'b0;
      started_high <= 1'b0;
    end else begin
      if (do_write) begin
        rise_t       <= '0;
        fall_t       <= '0;
        n_rise       <= '0;
        hit_seen     <= 1'b0;
        fall_seen    <= 1'b0;
        started_high <= 1'b0;
      end
      if (start_hi) begin
        started_high <= 1'b1;
        hit_seen     <= 1'b1;
        rise_t       <= '0;
      end
      if (set_rise) begin
        rise_t   <= t_cnt;
        hit_seen <= 1'b1;
      end
      if (inc_rise && (n_rise != 4'hF)) n_rise <= n_rise + 4'd1;
      if (set_fall) begin
        fall_t    <= t_cnt;
        fall_seen <= 1'b1;
      end
    end
  end

  assign record = {sel_r,
                   hit_seen  ? rise_t : T_MAX,
                   fall_seen ? fall_t : T_MAX,
                   n_rise, hit_seen, started_high, ~fall_seen, 1'b0};

  // a full FIFO still accepts a record when the host pops on the same cycle
  assign pop        = rd_en && (count != '0);
  assign wr_accept  = do_write && ((count != (FIFO_AW+1)'(DEPTH)) || rd_en);
  assign drop       = do_write && !wr_accept;
  assign count_next = count + (FIFO_AW+1)'(wr_accept) - (FIFO_AW+1)'(pop);

  // Record storage array
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= record;
  end

  // FIFO pointers, registered status flags, read port and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      rd_valid   <= pop;
      count      <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == (FIFO_AW+1)'(DEPTH));
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_hit_readout.sv
// Directed testbench for tdc_hit_readout with an expected-record scoreboard.
module tb_tdc_hit_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        measure_flag;
  logic [3:0]  SEL;
  logic        HIT;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        clear_overflow;
  logic        busy;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] sbQ [$];
  logic [31:0] lastData;
  logic        hitWave [0:255];

  localparam logic [31:0] REC_T1 = {4'd5, 10'd13, 10'd43, 4'd1, 4'b1000};
  localparam logic [31:0] REC_T3 = {4'd9, 10'd0, 10'd23, 4'd15, 4'b1100};

  tdc_hit_readout #(.FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .measure_flag(measure_flag), .SEL(SEL), .HIT(HIT),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] emptyRec(input logic [3:0] sel);
    return {sel, 10'h3FF, 10'h3FF, 4'd0, 4'b0010};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setWave(input int a, input int b, input logic v);
    for (int i = a; i < b; i++) hitWave[i] = v;
  endtask

  // One measurement window of len cycles; HIT follows hitWave, changing after each edge
  task automatic applyStimulus(input logic [3:0] sel, input int len, input bit popAtWrite,
                               input logic [31:0] expRec, input bit pushExp);
    SEL = sel;
    measure_flag = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 5) checkOutput("busy_in_window", {31'd0, busy}, 32'd1);
      HIT = hitWave[k];
      if (k == len - 1) measure_flag = 1'b0;
    end
    if (popAtWrite) begin
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (sbQ.size() > 0) begin
        checkOutput("pop_at_write_valid", {31'd0, rd_valid}, 32'd1);
        lastData = sbQ.pop_front();
        checkOutput("pop_at_write_data", rd_data, lastData);
      end else begin
        checkOutput("pop_at_write_empty_valid", {31'd0, rd_valid}, 32'd0);
      end
    end
    if (pushExp) sbQ.push_back(expRec);
  endtask

  task automatic popCheck(input string tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    if (sbQ.size() > 0) begin
      lastData = sbQ.pop_front();
      checkOutput({tag, "_data"}, rd_data, lastData);
    end else begin
      testsRun++;
      failCount++;
      $error("[TB] FAIL %s_sb observed=pop expected=no_record", tag);
    end
  endtask

  initial begin
    reset = 1'b0; measure_flag = 1'b0; SEL = '0; HIT = 1'b0;
    rd_en = 1'b0; clear_overflow = 1'b0; lastData = '0;
    setWave(0, 256, 1'b0);
    idle(3);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("rst_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(3);

    // rise at window cycle 10, fall at 40
    setWave(10, 40, 1'b1);
    applyStimulus(4'd5, 100, 1'b0, REC_T1, 1'b1);
    idle(3);
    checkOutput("t1_not_empty", {31'd0, fifo_empty}, 32'd0);
    checkOutput("t1_not_busy", {31'd0, busy}, 32'd0);
    popCheck("t1_pop");
    @(negedge clk);
    checkOutput("t1_valid_one_cycle", {31'd0, rd_valid}, 32'd0);
    checkOutput("t1_empty_after", {31'd0, fifo_empty}, 32'd1);

    // HIT low for the whole window
    setWave(0, 256, 1'b0);
    applyStimulus(4'd3, 30, 1'b0, emptyRec(4'd3), 1'b1);
    idle(3);
    popCheck("t2_pop");

    // HIT high before start, falls at 20, then 20 pulses
    HIT = 1'b1;
    idle(4);
    setWave(0, 256, 1'b0);
    setWave(0, 20, 1'b1);
    for (int p = 0; p < 20; p++) setWave(24 + 4 * p, 26 + 4 * p, 1'b1);
    applyStimulus(4'd9, 110, 1'b0, REC_T3, 1'b1);
    setWave(0, 256, 1'b0);
    HIT = 1'b0;
    idle(3);
    popCheck("t3_pop");

    // pop on empty FIFO is ignored and rd_data holds
    idle(1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("empty_pop_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("empty_pop_hold", rd_data, lastData);

    // write and read together on an empty FIFO: record kept
    applyStimulus(4'd2, 8, 1'b1, emptyRec(4'd2), 1'b1);
    idle(2);
    checkOutput("wr_rd_empty_stored", {31'd0, fifo_empty}, 32'd0);
    popCheck("wr_rd_empty_pop");
    idle(2);

    // fill past capacity
    for (int i = 0; i < 17; i++) begin
      applyStimulus(4'(i), 3, 1'b0, emptyRec(4'(i)), i < 16);
      idle(3);
      if (i == 15) begin
        checkOutput("full_after_16", {31'd0, fifo_full}, 32'd1);
        checkOutput("no_ovf_at_16", {31'd0, overflow}, 32'd0);
      end
    end
    checkOutput("ovf_after_17", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) popCheck("drain");
    idle(1);
    checkOutput("drained_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    // write on full with simultaneous pop
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(15 - i), 3, 1'b0, emptyRec(4'(15 - i)), 1'b1);
      idle(3);
    end
    checkOutput("refill_full", {31'd0, fifo_full}, 32'd1);
    applyStimulus(4'd12, 6, 1'b1, {4'd12, 10'h3FF, 10'h3FF, 4'd0, 4'b0010}, 1'b1);
    idle(2);
    checkOutput("full_pop_no_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("full_pop_still_full", {31'd0, fifo_full}, 32'd1);
    for (int i = 0; i < 16; i++) popCheck("drain2");
    idle(1);
    checkOutput("drain2_empty", {31'd0, fifo_empty}, 32'd1);

    // 1-cycle window then back-to-back window after a 1-cycle gap
    applyStimulus(4'd6, 1, 1'b0, emptyRec(4'd6), 1'b1);
    @(negedge clk);
    applyStimulus(4'd7, 8, 1'b0, emptyRec(4'd7), 1'b1);
    idle(3);
    popCheck("b2b_first");
    popCheck("b2b_second");
    idle(1);
    checkOutput("b2b_only_two", {31'd0, fifo_empty}, 32'd1);

    // reset mid-window with measure_flag held high
    applyStimulus(4'd4, 10, 1'b0, emptyRec(4'd4), 1'b1);
    idle(3);
    checkOutput("pre_reset_stored", {31'd0, fifo_empty}, 32'd0);
    SEL = 4'd8;
    measure_flag = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(2);
    sbQ.delete();
    checkOutput("midrst_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(20);
    checkOutput("held_flag_no_window", {31'd0, busy}, 32'd0);
    measure_flag = 1'b0;
    idle(4);
    checkOutput("held_flag_no_record", {31'd0, fifo_empty}, 32'd1);
    applyStimulus(4'd8, 10, 1'b0, emptyRec(4'd8), 1'b1);
    idle(3);
    popCheck("after_toggle");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
